// File: rtl/sd_drive_arbiter.sv
// sd_drive_arbiter
// Shares the single user_io SD sector channel between the two floppy drive
// units (drive 0 = A, drive 1 = B). Requests are arbitrated round-robin. The
// winner's LBA and operation are latched, and buffer traffic is routed only
// to the granted drive. A request whose ack never arrives is aborted after
// TIMEOUT_CYCLES, so one stuck drive cannot lock out the other.
//
// Ports:
//   clk_sys, reset           system clock, synchronous active-high reset
//   drv_lba[63:0]            {drive1 LBA, drive0 LBA}
//   drv_rd/drv_wr[1:0]       per-drive level requests
//   drv_ack[1:0]             sd_ack routed to the granted drive
//   drv_buff_addr/dout       broadcast of the user_io buffer bus
//   drv_buff_wr[1:0]         sd_dout_strobe gated to the granted drive
//   drv_buff_din[15:0]       {drive1 byte, drive0 byte}
//   sd_lba/sd_rd/sd_wr       request side toward user_io
//   sd_ack, sd_buff_addr, sd_buff_dout, sd_dout_strobe   from user_io
//   sd_buff_din              granted drive's write byte toward user_io
//   busy                     arbiter is not IDLE
//   timeout_err[1:0]         sticky per-drive abort flag
module sd_drive_arbiter #(
  parameter int              TW             = 24,
  parameter logic [TW-1:0]   TIMEOUT_CYCLES = 24'd6400000
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic [63:0]  drv_lba,
  input  logic [1:0]   drv_rd,
  input  logic [1:0]   drv_wr,
  output logic [1:0]   drv_ack,
  output logic [8:0]   drv_buff_addr,
  output logic [7:0]   drv_buff_dout,
  output logic [1:0]   drv_buff_wr,
  input  logic [15:0]  drv_buff_din,
  output logic [31:0]  sd_lba,
  output logic         sd_rd,
  output logic         sd_wr,
  input  logic         sd_ack,
  input  logic [8:0]   sd_buff_addr,
  input  logic [7:0]   sd_buff_dout,
  input  logic         sd_dout_strobe,
  output logic [7:0]   sd_buff_din,
  output logic         busy,
  output logic [1:0]   timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  localparam logic [TW-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - TW'(1);

  state_t         state, state_next;
  logic           grant, grant_next;
  logic           last_grant, last_grant_next;
  logic           op_wr, op_wr_next;
  logic [31:0]    lba_next;
  logic           rd_next, wr_next;
  logic [TW-1:0]  timer, timer_next;
  logic [1:0]     err_next;
  logic [1:0]     req;
  logic           pick;

  assign req = drv_rd | drv_wr;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      op_wr       <= 1'b0;
      sd_lba      <= '0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      timer       <= '0;
      timeout_err <= '0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      last_grant  <= last_grant_next;
      op_wr       <= op_wr_next;
      sd_lba      <= lba_next;
      sd_rd       <= rd_next;
      sd_wr       <= wr_next;
      timer       <= timer_next;
      timeout_err <= err_next;
    end
  end

  // sd_rd/sd_wr default low so they drop on any exit from REQ (ack or abort).
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    op_wr_next      = op_wr;
    lba_next        = sd_lba;
    rd_next         = 1'b0;
    wr_next         = 1'b0;
    timer_next      = timer;
    err_next        = timeout_err;
    pick            = 1'b0;
    case (state)
      IDLE: begin
        timer_next = '0;
        if (req != 2'b00) begin
          // On contention the drive that was not served last wins.
          pick       = (req == 2'b11) ? ~last_grant : req[1];
          grant_next = pick;
          lba_next   = pick ? drv_lba[63:32] : drv_lba[31:0];
          op_wr_next = drv_wr[pick] & ~drv_rd[pick];
          state_next = REQ;
        end
      end
      REQ: begin
        if (sd_ack) begin
          timer_next = '0;
          state_next = XFER;
        end else if (timer == TIMEOUT_LAST) begin
          err_next[grant] = 1'b1;
          last_grant_next = grant;
          timer_next      = '0;
          state_next      = IDLE;
        end else begin
          rd_next = ~op_wr;
          wr_next = op_wr;
          if (timer != '1) timer_next = timer + TW'(1);
        end
      end
      XFER: begin
        if (!sd_ack) begin
          err_next[grant] = 1'b0;
          state_next      = DONE;
        end
      end
      DONE: begin
        // Hold until the drive withdraws, so its request is not re-granted.
        if (!(drv_rd[grant] | drv_wr[grant])) begin
          last_grant_next = grant;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer traffic reaches only the granted drive, and only while transferring.
  always_comb begin
    drv_ack     = '0;
    drv_buff_wr = '0;
    sd_buff_din = '0;
    if (state == XFER) begin
      drv_ack[grant]     = sd_ack;
      drv_buff_wr[grant] = sd_dout_strobe;
      sd_buff_din        = grant ? drv_buff_din[15:8] : drv_buff_din[7:0];
    end
  end

  assign drv_buff_addr = sd_buff_addr;
  assign drv_buff_dout = sd_buff_dout;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Testbench for sd_drive_arbiter. The bench plays both floppy drives and the
// user_io host. Expected grants come from a round-robin model that tracks
// only which drive was served last.
module tb_sd_drive_arbiter;

  localparam int TW  = 24;
  localparam int TMO = 16;

  logic         clk_sys = 1'b0;
  logic         reset;
  logic [63:0]  drv_lba;
  logic [1:0]   drv_rd, drv_wr;
  logic [1:0]   drv_ack;
  logic [8:0]   drv_buff_addr;
  logic [7:0]   drv_buff_dout;
  logic [1:0]   drv_buff_wr;
  logic [15:0]  drv_buff_din;
  logic [31:0]  sd_lba;
  logic         sd_rd, sd_wr;
  logic         sd_ack;
  logic [8:0]   sd_buff_addr;
  logic [7:0]   sd_buff_dout;
  logic         sd_dout_strobe;
  logic [7:0]   sd_buff_din;
  logic         busy;
  logic [1:0]   timeout_err;

  int nvec = 0;
  int nerr = 0;
  int model_last;

  logic [31:0] obs_lba;
  logic        obs_rd, obs_wr, obs_rdwr_after;
  logic [1:0]  obs_ack, obs_bwr_or;
  int          obs_bwr_cnt, obs_din_bad, obs_bcast_bad;

  sd_drive_arbiter #(.TW(TW), .TIMEOUT_CYCLES(24'd16)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .drv_lba(drv_lba), .drv_rd(drv_rd), .drv_wr(drv_wr), .drv_ack(drv_ack),
    .drv_buff_addr(drv_buff_addr), .drv_buff_dout(drv_buff_dout),
    .drv_buff_wr(drv_buff_wr), .drv_buff_din(drv_buff_din),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_dout_strobe(sd_dout_strobe), .sd_buff_din(sd_buff_din),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Round-robin rule: on contention the drive not served last wins.
  function automatic int model_pick(input logic [1:0] req, input int last);
    if (req[0] && req[1]) return 1 - last;
    return req[1] ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Host side of one transaction, starting in IDLE with requests already set.
  // Stops in DONE, with the requests still held.
  task automatic serve(input int ack_delay, input int nbytes, input logic [7:0] exp_din);
    tick();
    drv_lba = {$urandom, $urandom};
    tick();
    obs_lba = sd_lba;
    obs_rd  = sd_rd;
    obs_wr  = sd_wr;
    repeat (ack_delay) tick();
    sd_ack = 1'b1;
    tick();
    obs_ack        = drv_ack;
    obs_rdwr_after = sd_rd | sd_wr;
    obs_bwr_or     = '0;
    obs_bwr_cnt    = 0;
    obs_din_bad    = 0;
    obs_bcast_bad  = 0;
    for (int i = 0; i < nbytes; i++) begin
      sd_dout_strobe = 1'b1;
      sd_buff_addr   = 9'(i);
      sd_buff_dout   = 8'($urandom);
      #1;
      obs_bwr_or = obs_bwr_or | drv_buff_wr;
      if (drv_buff_wr != 2'b00) obs_bwr_cnt++;
      if (sd_buff_din !== exp_din) obs_din_bad++;
      if (drv_buff_addr !== sd_buff_addr || drv_buff_dout !== sd_buff_dout) obs_bcast_bad++;
      tick();
    end
    sd_dout_strobe = 1'b0;
    sd_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv_lba = '0; drv_rd = '0; drv_wr = '0; drv_buff_din = '0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_dout_strobe = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_last = 1;
    nvec++; if ({sd_rd, sd_wr, busy} !== 3'b000) begin nerr++; $display("[TB] FAIL reset_ctrl got %b want 000", {sd_rd, sd_wr, busy}); end
    nvec++; if (sd_lba !== 32'h0) begin nerr++; $display("[TB] FAIL reset_lba got %h want 0", sd_lba); end
    nvec++; if (timeout_err !== 2'b00) begin nerr++; $display("[TB] FAIL reset_err got %b want 00", timeout_err); end
    nvec++; if ({drv_ack, drv_buff_wr, sd_buff_din} !== 12'h0) begin nerr++; $display("[TB] FAIL reset_comb got %h want 0", {drv_ack, drv_buff_wr, sd_buff_din}); end
  endtask

  task automatic test_single_read();
    int w;
    logic [31:0] exp_lba;
    logic [7:0] exp_din;
    drv_lba = {$urandom, 32'h0000_0012};
    drv_rd = 2'b01; drv_wr = 2'b00;
    drv_buff_din = 16'($urandom);
    w = model_pick(drv_rd | drv_wr, model_last);
    exp_lba = (w == 1) ? drv_lba[63:32] : drv_lba[31:0];
    exp_din = (w == 1) ? drv_buff_din[15:8] : drv_buff_din[7:0];
    serve(3, 512, exp_din);
    nvec++; if (obs_lba !== exp_lba) begin nerr++; $display("[TB] FAIL read_lba got %h want %h", obs_lba, exp_lba); end
    nvec++; if ({obs_rd, obs_wr} !== 2'b10) begin nerr++; $display("[TB] FAIL read_rdwr got %b want 10", {obs_rd, obs_wr}); end
    nvec++; if (obs_ack !== 2'(1 << w)) begin nerr++; $display("[TB] FAIL read_ack got %b want %b", obs_ack, 2'(1 << w)); end
    nvec++; if (obs_rdwr_after !== 1'b0) begin nerr++; $display("[TB] FAIL read_rd_drop got %b want 0", obs_rdwr_after); end
    nvec++; if (obs_bwr_or !== 2'(1 << w)) begin nerr++; $display("[TB] FAIL read_bwr_route got %b want %b", obs_bwr_or, 2'(1 << w)); end
    nvec++; if (obs_bwr_cnt !== 512) begin nerr++; $display("[TB] FAIL read_bwr_count got %0d want 512", obs_bwr_cnt); end
    nvec++; if (obs_bcast_bad !== 0) begin nerr++; $display("[TB] FAIL read_broadcast got %0d bad want 0", obs_bcast_bad); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("[TB] FAIL read_done_busy got %b want 1", busy); end
    drv_rd = 2'b00;
    tick();
    model_last = w;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("[TB] FAIL read_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_both_same_cycle();
    logic [31:0] lba0, lba1, exp_lba;
    int w;
    lba0 = $urandom; lba1 = $urandom;
    drv_lba = {lba1, lba0};
    drv_rd = 2'b11; drv_wr = 2'b00;
    for (int r = 0; r < 3; r++) begin
      w = model_pick(drv_rd | drv_wr, model_last);
      exp_lba = (w == 1) ? lba1 : lba0;
      serve(1, 4, (w == 1) ? drv_buff_din[15:8] : drv_buff_din[7:0]);
      nvec++; if (obs_lba !== exp_lba) begin nerr++; $display("[TB] FAIL both_lba round %0d got %h want %h", r, obs_lba, exp_lba); end
      nvec++; if (obs_ack !== 2'(1 << w)) begin nerr++; $display("[TB] FAIL both_ack round %0d got %b want %b", r, obs_ack, 2'(1 << w)); end
      drv_rd[w] = 1'b0;
      tick();
      model_last = w;
      drv_lba = {lba1, lba0};
      if (r == 1) drv_rd = 2'b11;
    end
    drv_rd = 2'b00;
    tick();
  endtask

  task automatic test_write_drive1();
    int w;
    logic [31:0] exp_lba;
    drv_lba = {$urandom, $urandom};
    drv_rd = 2'b00; drv_wr = 2'b10;
    drv_buff_din = 16'hA55A;
    w = model_pick(drv_rd | drv_wr, model_last);
    exp_lba = (w == 1) ? drv_lba[63:32] : drv_lba[31:0];
    serve(2, 16, 8'hA5);
    nvec++; if (obs_lba !== exp_lba) begin nerr++; $display("[TB] FAIL write_lba got %h want %h", obs_lba, exp_lba); end
    nvec++; if ({obs_rd, obs_wr} !== 2'b01) begin nerr++; $display("[TB] FAIL write_rdwr got %b want 01", {obs_rd, obs_wr}); end
    nvec++; if (obs_din_bad !== 0) begin nerr++; $display("[TB] FAIL write_din got %0d bad bytes want 0", obs_din_bad); end
    nvec++; if (obs_bwr_or !== 2'b10) begin nerr++; $display("[TB] FAIL write_bwr_route got %b want 10", obs_bwr_or); end
    drv_wr = 2'b00;
    tick();
    model_last = w;
  endtask

  task automatic test_timeout();
    logic [31:0] lba1;
    logic [1:0] ack_seen;
    logic rd_before;
    int w;
    lba1 = $urandom;
    drv_lba = {lba1, $urandom};
    drv_rd = 2'b01; drv_wr = 2'b00;
    ack_seen = '0; rd_before = 1'b0;
    tick();
    drv_rd = 2'b11;
    for (int k = 1; k <= TMO; k++) begin
      tick();
      ack_seen = ack_seen | drv_ack;
      if (k == TMO - 1) rd_before = sd_rd;
    end
    model_last = 0;
    nvec++; if (rd_before !== 1'b1) begin nerr++; $display("[TB] FAIL tmo_rd_before got %b want 1", rd_before); end
    nvec++; if ({sd_rd, busy} !== 2'b00) begin nerr++; $display("[TB] FAIL tmo_abort got %b want 00", {sd_rd, busy}); end
    nvec++; if (timeout_err !== 2'b01) begin nerr++; $display("[TB] FAIL tmo_err got %b want 01", timeout_err); end
    nvec++; if (ack_seen !== 2'b00) begin nerr++; $display("[TB] FAIL tmo_no_ack got %b want 00", ack_seen); end
    w = model_pick(drv_rd | drv_wr, model_last);
    serve(2, 4, drv_buff_din[15:8]);
    nvec++; if (obs_lba !== lba1 || w != 1) begin nerr++; $display("[TB] FAIL tmo_next_lba got %h want %h", obs_lba, lba1); end
    nvec++; if (obs_ack !== 2'(1 << w)) begin nerr++; $display("[TB] FAIL tmo_next_ack got %b want %b", obs_ack, 2'(1 << w)); end
    drv_rd = 2'b00;
    tick();
    model_last = w;
    nvec++; if (timeout_err !== 2'b01) begin nerr++; $display("[TB] FAIL tmo_sticky got %b want 01", timeout_err); end
  endtask

  task automatic test_reset_mid_xfer();
    drv_lba = {$urandom, $urandom};
    drv_rd = 2'b01; drv_wr = 2'b00;
    tick(); tick();
    sd_ack = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      sd_dout_strobe = 1'b1; sd_buff_addr = 9'(i);
      tick();
    end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("[TB] FAIL rst_mid_busy_before got %b want 1", busy); end
    sd_buff_addr = 9'd100;
    reset = 1'b1;
    tick();
    nvec++; if ({sd_rd, sd_wr, busy} !== 3'b000) begin nerr++; $display("[TB] FAIL rst_mid_ctrl got %b want 000", {sd_rd, sd_wr, busy}); end
    nvec++; if ({drv_ack, drv_buff_wr} !== 4'b0000) begin nerr++; $display("[TB] FAIL rst_mid_route got %b want 0000", {drv_ack, drv_buff_wr}); end
    nvec++; if (timeout_err !== 2'b00) begin nerr++; $display("[TB] FAIL rst_mid_err got %b want 00", timeout_err); end
    reset = 1'b0; sd_ack = 1'b0; sd_dout_strobe = 1'b0; drv_rd = 2'b00;
    model_last = 1;
    tick();
  endtask

  task automatic test_stray();
    for (int k = 0; k < 4; k++) begin
      sd_ack = 1'($urandom); sd_dout_strobe = 1'b1;
      #1;
      nvec++; if ({drv_ack, drv_buff_wr} !== 4'b0000) begin nerr++; $display("[TB] FAIL stray_route got %b want 0000", {drv_ack, drv_buff_wr}); end
      tick();
      nvec++; if (busy !== 1'b0) begin nerr++; $display("[TB] FAIL stray_busy got %b want 0", busy); end
    end
    sd_ack = 1'b0; sd_dout_strobe = 1'b0;
    tick();
  endtask

  task automatic test_random_traffic();
    int w;
    logic exp_wr;
    logic [31:0] exp_lba;
    logic [7:0] exp_din;
    for (int it = 0; it < 25; it++) begin
      do begin
        drv_rd = 2'($urandom); drv_wr = 2'($urandom);
      end while ((drv_rd | drv_wr) == 2'b00);
      drv_lba = {$urandom, $urandom};
      drv_buff_din = 16'($urandom);
      w = model_pick(drv_rd | drv_wr, model_last);
      exp_wr  = drv_wr[w] & ~drv_rd[w];
      exp_lba = (w == 1) ? drv_lba[63:32] : drv_lba[31:0];
      exp_din = (w == 1) ? drv_buff_din[15:8] : drv_buff_din[7:0];
      serve(int'($urandom_range(0, 5)), int'($urandom_range(1, 8)), exp_din);
      nvec++; if (obs_lba !== exp_lba) begin nerr++; $display("[TB] FAIL rnd_lba it %0d got %h want %h", it, obs_lba, exp_lba); end
      nvec++; if ({obs_rd, obs_wr} !== {~exp_wr, exp_wr}) begin nerr++; $display("[TB] FAIL rnd_rdwr it %0d got %b want %b", it, {obs_rd, obs_wr}, {~exp_wr, exp_wr}); end
      nvec++; if (obs_ack !== 2'(1 << w) || obs_bwr_or !== 2'(1 << w)) begin nerr++; $display("[TB] FAIL rnd_route it %0d got ack %b bwr %b want %b", it, obs_ack, obs_bwr_or, 2'(1 << w)); end
      nvec++; if (obs_din_bad !== 0) begin nerr++; $display("[TB] FAIL rnd_din it %0d got %0d bad want 0", it, obs_din_bad); end
      drv_rd[w] = 1'b0; drv_wr[w] = 1'b0;
      tick();
      model_last = w;
    end
    drv_rd = 2'b00; drv_wr = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_both_same_cycle();
    test_write_drive1();
    test_timeout();
    test_reset_mid_xfer();
    test_stray();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sd_drive_arbiter.md
Name: sd_drive_arbiter

Overview:
- Shares the single user_io SD sector channel (lba/rd/wr/ack, buffer address/data/strobe) between the two floppy drive units inside pcw_core (drive A, drive B).
- Arbitrates round-robin, latches the winner's LBA and operation, and routes the buffer traffic to the granted drive only.
- Aborts a request whose ack never arrives, so one stuck drive cannot lock out the other.

Parameters:
- TIMEOUT_CYCLES, 24'd6400000, clk_sys cycles in REQ without sd_ack before abort (100 ms at 64 MHz).
- TW, 24, width of the timeout counter.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- drv_lba  in  64  [31:0] drive 0 LBA, [63:32] drive 1 LBA.
- drv_rd  in  2  per-drive read request, level, held until the drive sees its ack.
- drv_wr  in  2  per-drive write request, level.
- drv_ack  out  2  per-drive ack; copy of sd_ack on the granted bit only.
- drv_buff_addr  out  9  broadcast of sd_buff_addr.
- drv_buff_dout  out  8  broadcast of sd_buff_dout.
- drv_buff_wr  out  2  sd_dout_strobe, gated to the granted drive.
- drv_buff_din  in  16  [7:0] drive 0 write data, [15:8] drive 1 write data.
- sd_lba  out  32  to user_io.
- sd_rd  out  1  to user_io.
- sd_wr  out  1  to user_io.
- sd_ack  in  1  from user_io.
- sd_buff_addr  in  9  from user_io.
- sd_buff_dout  in  8  from user_io.
- sd_dout_strobe  in  1  from user_io.
- sd_buff_din  out  8  granted drive's byte.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  2  sticky per-drive abort flag.

Behaviour:
- Reset values:
  - state=IDLE, grant=0, last_grant=1 (so drive 0 has first priority).
  - sd_rd=sd_wr=0, sd_lba=0, busy=0, timeout_err=0, timer=0.
  - drv_ack, drv_buff_wr and sd_buff_din are combinational off grant and state; they read 0 in IDLE.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - req[i] = drv_rd[i] | drv_wr[i].
  - If both drives request, the drive != last_grant wins; otherwise the sole requester wins.
  - On the same edge: latch grant, sd_lba <= drv_lba slice, op_wr <= drv_wr[g] & ~drv_rd[g] (read wins if both are set). Next state is REQ.
  - Latency: request sampled at edge N, so sd_rd/sd_wr are high after edge N+1.
- REQ:
  - sd_rd = ~op_wr, sd_wr = op_wr; both registered and held stable. sd_lba is held.
  - timer increments each cycle.
  - sd_ack=1 -> XFER, timer cleared.
  - timer == TIMEOUT_CYCLES-1 with no ack -> abort: timeout_err[grant] <= 1, sd_rd/sd_wr <= 0, last_grant <= grant, go to IDLE. drv_ack is never pulsed for an aborted request.
- XFER:
  - sd_rd/sd_wr deasserted on entry.
  - drv_ack[grant] = sd_ack.
  - drv_buff_wr[grant] = sd_dout_strobe; the other bit stays 0.
  - sd_buff_din = drv_buff_din byte of grant.
  - sd_ack falling -> DONE. timeout_err[grant] <= 0 (cleared on a successful transfer).
- DONE:
  - Wait until drv_rd[grant] | drv_wr[grant] == 0, then last_grant <= grant and go to IDLE.
  - This wait prevents a re-grant of a request the drive has not yet withdrawn.
- Stray inputs: sd_ack or sd_dout_strobe arriving in IDLE or DONE is ignored; drv_ack and drv_buff_wr stay 0.
- New requests from the non-granted drive during REQ, XFER or DONE are held off and not lost, because requests are level signals.
- drv_lba changes after the latch edge do not affect sd_lba until the next IDLE grant.
- Reset asserted mid-transfer returns to the reset values on the next edge; sd_rd/sd_wr drop immediately (one cycle).
- Timer width TW must hold TIMEOUT_CYCLES; the counter saturates and never wraps.

Test Plan:
- Drive 0 read only, lba=0x00000012:
  - sd_rd=1 and sd_lba=0x12 one cycle after request.
  - sd_ack raised 3 cycles later: sd_rd=0, drv_ack=2'b01.
  - 512 strobes reach drv_buff_wr[0] only.
  - Ack falls and drive drops its request: back to IDLE, busy=0.
- Both drives request in the same cycle after reset:
  - Drive 0 granted first.
  - After completion, drive 1 is granted with its lba.
  - A repeated simultaneous request then grants drive 0 again (alternation).
- Drive 1 write, drv_buff_din[15:8]=0xA5, drv_buff_din[7:0]=0x5A: sd_wr=1, sd_rd=0, sd_buff_din=0xA5 throughout XFER.
- Timeout with TIMEOUT_CYCLES=16 and no sd_ack:
  - After 16 REQ cycles: sd_rd=0, timeout_err=2'b01, drv_ack never 1.
  - A pending drive 1 request is granted next.
- Stray sd_ack and sd_dout_strobe pulses in IDLE: drv_ack=0, drv_buff_wr=0, state stays IDLE.
- reset pulsed for 1 cycle during XFER at byte 100: next cycle sd_rd=sd_wr=0, busy=0, drv_ack=0, timeout_err=0.
